// File: rtl/data_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter_pkg
//   Shared constants for the data RAM arbiter:
//     - default address/data widths (match the CPU data port)
//     - requester indices into the grant vector
//     - default limit on consecutive CPU grants while the host waits
// -----------------------------------------------------------------------------
package data_mem_arbiter_pkg;

  localparam int AW_DEF             = 15;
  localparam int DW_DEF             = 16;
  localparam int CPU_MAX_CONSEC_DEF = 4;

  // Width of the starvation counter; limits CPU_MAX_CONSEC to 1..15.
  localparam int CONSEC_W = 4;

  localparam int REQ_CPU  = 0;
  localparam int REQ_HOST = 1;
  localparam int NUM_REQ  = 2;

  typedef logic [NUM_REQ-1:0] gnt_vec_t;

endpackage

// File: rtl/arb_starve_counter.sv
// -----------------------------------------------------------------------------
// arb_starve_counter
//   Saturating count of consecutive CPU grants taken while the host waits.
//   Clear has priority over increment.
//   Ports:
//     clk       clock, rising edge
//     rst       synchronous active-high reset (count -> 0)
//     inc_i     count one more CPU grant (saturates at MAX)
//     clr_i     clear the count
//     at_max_o  count has reached MAX; the host must win the next contest
// -----------------------------------------------------------------------------
module arb_starve_counter #(
  parameter int W   = 4,
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != MAX_V)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_max_o = (count_q == MAX_V);

endmodule

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//   Shares the single-port data RAM between the CPU data port and the host
//   (debug/loader) port. The CPU has fixed priority; a starvation counter
//   forces a host grant after CPU_MAX_CONSEC back-to-back CPU wins, and a
//   host lock keeps the CPU out for atomic host bursts.
//   Ports:
//     CPUclk, rst                       clock / synchronous active-high reset
//     cpu_req/we/addr/wdata             CPU request (held until cpu_gnt)
//     cpu_gnt, cpu_stall, cpu_rvalid    CPU grant, stall, read-data valid
//     host_req/we/addr/wdata/lock       host request and lock
//     host_gnt, host_rvalid             host grant, read-data valid
//     rdata                             read data shared by both rvalids
//     ram_addr/we/wdata, ram_rdata      RAM macro port (1-cycle read latency)
// -----------------------------------------------------------------------------
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int AW             = AW_DEF,
  parameter int DW             = DW_DEF,
  parameter int CPU_MAX_CONSEC = CPU_MAX_CONSEC_DEF
) (
  input  logic          CPUclk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  input  logic          host_lock,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  gnt_vec_t      gnt;
  logic          at_max;
  logic          lock_eff;
  logic          locked_q;
  logic          locked_d;
  logic          cpu_rvalid_q;
  logic          host_rvalid_q;
  logic          rvalid_any;
  logic [DW-1:0] rdata_q;

  // Dropping host_lock releases the CPU in the very same cycle.
  assign lock_eff = locked_q & host_lock;

  // Grant selection. Under an effective lock only the host may be granted,
  // and an idle locked host blocks everyone (keeps read-modify-write atomic).
  always_comb begin
    gnt = '0;
    if (!rst) begin
      if (lock_eff) begin
        gnt[REQ_HOST] = host_req;
      end else if (host_req && (!cpu_req || at_max)) begin
        gnt[REQ_HOST] = 1'b1;
      end else if (cpu_req) begin
        gnt[REQ_CPU] = 1'b1;
      end
    end
  end

  assign cpu_gnt   = gnt[REQ_CPU];
  assign host_gnt  = gnt[REQ_HOST];
  assign cpu_stall = cpu_req & ~gnt[REQ_CPU] & ~rst;

  // RAM port follows the granted requester; idles on the CPU address.
  assign ram_addr  = gnt[REQ_HOST] ? host_addr  : cpu_addr;
  assign ram_wdata = gnt[REQ_HOST] ? host_wdata : cpu_wdata;
  assign ram_we    = (gnt[REQ_CPU] & cpu_we) | (gnt[REQ_HOST] & host_we);

  arb_starve_counter #(
    .W   (CONSEC_W),
    .MAX (CPU_MAX_CONSEC)
  ) u_starve (
    .clk      (CPUclk),
    .rst      (rst),
    .inc_i    (gnt[REQ_CPU] & host_req),
    .clr_i    (gnt[REQ_HOST] | ~host_req),
    .at_max_o (at_max)
  );

  always_comb begin
    locked_d = locked_q;
    if (!host_lock) begin
      locked_d = 1'b0;
    end else if (gnt[REQ_HOST]) begin
      locked_d = 1'b1;
    end
  end

  always_ff @(posedge CPUclk) begin
    if (rst) begin
      locked_q      <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      rdata_q       <= '0;
    end else begin
      locked_q      <= locked_d;
      cpu_rvalid_q  <= gnt[REQ_CPU] & ~cpu_we;
      host_rvalid_q <= gnt[REQ_HOST] & ~host_we;
      if (rvalid_any) begin
        rdata_q <= ram_rdata;
      end
    end
  end

  // The RAM output register already supplies the one-cycle latency, so the
  // returned word passes straight through while an rvalid is high and is
  // then held stable in rdata_q until the next read returns.
  assign rvalid_any  = cpu_rvalid_q | host_rvalid_q;
  assign rdata       = rvalid_any ? ram_rdata : rdata_q;
  assign cpu_rvalid  = cpu_rvalid_q;
  assign host_rvalid = host_rvalid_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

  localparam int AW   = 15;
  localparam int DW   = 16;
  localparam int MAXC = 4;

  logic          CPUclk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_stall, cpu_rvalid;
  logic          host_req, host_we, host_lock;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  int tests = 0;
  int fails = 0;

  always #5 CPUclk = ~CPUclk;

  data_mem_arbiter #(.AW(AW), .DW(DW), .CPU_MAX_CONSEC(MAXC)) dut (
    .CPUclk      (CPUclk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_gnt     (cpu_gnt),
    .cpu_stall   (cpu_stall),
    .cpu_rvalid  (cpu_rvalid),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_lock   (host_lock),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .rdata       (rdata),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  // Synchronous RAM macro stand-in: 256 words, 1-cycle read latency.
  logic [DW-1:0] ram_mem [0:255];
  logic          ram_init;

  always @(posedge CPUclk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= 16'hA000 + 16'(i);
    end else if (ram_we) begin
      ram_mem[ram_addr[7:0]] <= ram_wdata;
    end
    ram_rdata <= ram_mem[ram_addr[7:0]];
  end

  task automatic step();
    @(posedge CPUclk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0003; cpu_wdata = 16'hBEEF;
    host_req = 1'b1; host_we = 1'b1; host_addr = 15'h0004; host_wdata = 16'h0F0F;
    host_lock = 1'b1;
    step();
    step();
    @(negedge CPUclk);
    tests++; if (cpu_gnt !== 1'b0) begin fails++; $display("FAIL reset_cpu_gnt: got %b want 0", cpu_gnt); end
    tests++; if (host_gnt !== 1'b0) begin fails++; $display("FAIL reset_host_gnt: got %b want 0", host_gnt); end
    tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
    tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
    tests++; if (ram_addr !== 15'h0003) begin fails++; $display("FAIL reset_ram_addr: got %h want 0003", ram_addr); end
    tests++; if ({cpu_rvalid, host_rvalid} !== 2'b00) begin fails++; $display("FAIL reset_rvalid: got %b want 00", {cpu_rvalid, host_rvalid}); end
    tests++; if (rdata !== 16'h0000) begin fails++; $display("FAIL reset_rdata: got %h want 0000", rdata); end
    $display("tx: reset held, no grants");
    step();
    rst = 1'b0;
    host_lock = 1'b0;
    idle_inputs();
    step();
  endtask

  task automatic test_cpu_only();
    host_req = 1'b0;
    cpu_req  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cpu_we   = 1'b0;
      cpu_addr = 15'($urandom_range(0, 255));
      @(negedge CPUclk);
      tests++;
      if ({cpu_gnt, cpu_stall, host_gnt} !== 3'b100) begin
        fails++; $display("FAIL cpu_only_%0d: gnt/stall/hgnt got %b want 100", k, {cpu_gnt, cpu_stall, host_gnt});
      end
      $display("tx: cpu_only k=%0d CPU rd addr=%h", k, cpu_addr);
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_starvation();
    logic exp_h;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0007;
    host_req = 1'b1; host_we = 1'b0; host_addr = 15'h0008; host_lock = 1'b0;
    for (int k = 0; k < 15; k++) begin
      exp_h = ((k % 5) == 4);
      @(negedge CPUclk);
      tests++;
      if ({cpu_gnt, host_gnt, cpu_stall} !== {~exp_h, exp_h, exp_h}) begin
        fails++; $display("FAIL starve_%0d: cgnt/hgnt/stall got %b want %b", k, {cpu_gnt, host_gnt, cpu_stall}, {~exp_h, exp_h, exp_h});
      end
      $display("tx: starve k=%0d winner=%s", k, host_gnt ? "HOST" : (cpu_gnt ? "CPU" : "none"));
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_host_write_cpu_read();
    host_req = 1'b1; host_we = 1'b1; host_addr = 15'h0010; host_wdata = 16'h1234;
    @(negedge CPUclk);
    tests++; if ({host_gnt, cpu_gnt} !== 2'b10) begin fails++; $display("FAIL hw_gnt: got %b want 10", {host_gnt, cpu_gnt}); end
    tests++; if (ram_we !== 1'b1) begin fails++; $display("FAIL hw_ram_we: got %b want 1", ram_we); end
    tests++; if (ram_addr !== 15'h0010) begin fails++; $display("FAIL hw_ram_addr: got %h want 0010", ram_addr); end
    tests++; if (ram_wdata !== 16'h1234) begin fails++; $display("FAIL hw_ram_wdata: got %h want 1234", ram_wdata); end
    $display("tx: HOST wr addr=0010 data=1234");
    step();
    idle_inputs();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0010;
    @(negedge CPUclk);
    tests++; if (cpu_gnt !== 1'b1) begin fails++; $display("FAIL cr_gnt: got %b want 1", cpu_gnt); end
    tests++; if (host_rvalid !== 1'b0) begin fails++; $display("FAIL hw_no_rvalid: got %b want 0", host_rvalid); end
    $display("tx: CPU rd addr=0010");
    step();
    idle_inputs();
    @(negedge CPUclk);
    tests++; if ({cpu_rvalid, host_rvalid} !== 2'b10) begin fails++; $display("FAIL cr_rvalid: got %b want 10", {cpu_rvalid, host_rvalid}); end
    tests++; if (rdata !== 16'h1234) begin fails++; $display("FAIL cr_rdata: got %h want 1234", rdata); end
    step();
    @(negedge CPUclk);
    tests++; if (cpu_rvalid !== 1'b0) begin fails++; $display("FAIL cr_rvalid_once: got %b want 0", cpu_rvalid); end
    step();
  endtask

  task automatic test_lock();
    logic exp_h;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0005;
    host_req = 1'b1; host_we = 1'b0; host_addr = 15'h0020; host_lock = 1'b1;
    // Host first has to win by starvation; the lock then holds the CPU off.
    for (int k = 0; k < 5; k++) begin
      exp_h = (k == 4);
      @(negedge CPUclk);
      tests++;
      if ({cpu_gnt, host_gnt} !== {~exp_h, exp_h}) begin
        fails++; $display("FAIL lock_enter_%0d: cgnt/hgnt got %b want %b", k, {cpu_gnt, host_gnt}, {~exp_h, exp_h});
      end
      step();
    end
    $display("tx: HOST locked rd addr=0020");
    host_we = 1'b1; host_wdata = 16'h5A5A;
    @(negedge CPUclk);
    tests++; if ({cpu_gnt, host_gnt} !== 2'b01) begin fails++; $display("FAIL lock_wr_gnt: got %b want 01", {cpu_gnt, host_gnt}); end
    tests++; if (host_rvalid !== 1'b1) begin fails++; $display("FAIL lock_rd_rvalid: got %b want 1", host_rvalid); end
    tests++; if (rdata !== 16'hA020) begin fails++; $display("FAIL lock_rd_rdata: got %h want a020", rdata); end
    $display("tx: HOST locked wr addr=0020 data=5a5a");
    step();
    host_req = 1'b0; host_we = 1'b0;
    @(negedge CPUclk);
    tests++; if ({cpu_gnt, host_gnt, cpu_stall, ram_we} !== 4'b0010) begin fails++; $display("FAIL lock_hold: cgnt/hgnt/stall/we got %b want 0010", {cpu_gnt, host_gnt, cpu_stall, ram_we}); end
    step();
    host_lock = 1'b0;
    @(negedge CPUclk);
    tests++; if ({cpu_gnt, cpu_stall} !== 2'b10) begin fails++; $display("FAIL lock_release: cgnt/stall got %b want 10", {cpu_gnt, cpu_stall}); end
    $display("tx: lock dropped, CPU rd addr=0005");
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    host_req = 1'b1; host_we = 1'b0; host_addr = 15'h0020; host_lock = 1'b0;
    @(negedge CPUclk);
    tests++; if (host_gnt !== 1'b1) begin fails++; $display("FAIL rmid_hgnt: got %b want 1", host_gnt); end
    step();
    rst = 1'b1;
    host_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0030; cpu_wdata = 16'hDEAD;
    @(negedge CPUclk);
    tests++; if ({cpu_gnt, host_gnt, ram_we} !== 3'b000) begin fails++; $display("FAIL rmid_in_reset: cgnt/hgnt/we got %b want 000", {cpu_gnt, host_gnt, ram_we}); end
    step();
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0030;
    host_req = 1'b1; host_we = 1'b0; host_addr = 15'h0031;
    @(negedge CPUclk);
    tests++; if ({cpu_rvalid, host_rvalid} !== 2'b00) begin fails++; $display("FAIL rmid_rvalid_drop: got %b want 00", {cpu_rvalid, host_rvalid}); end
    tests++; if (rdata !== 16'h0000) begin fails++; $display("FAIL rmid_rdata: got %h want 0000", rdata); end
    tests++; if ({cpu_gnt, host_gnt} !== 2'b10) begin fails++; $display("FAIL rmid_cpu_first: got %b want 10", {cpu_gnt, host_gnt}); end
    $display("tx: after reset CPU rd addr=0030");
    step();
    cpu_req = 1'b0;
    @(negedge CPUclk);
    tests++; if (cpu_rvalid !== 1'b1) begin fails++; $display("FAIL rmid_cpu_rvalid: got %b want 1", cpu_rvalid); end
    tests++; if (rdata !== 16'hA030) begin fails++; $display("FAIL rmid_no_write: got %h want a030", rdata); end
    tests++; if (host_gnt !== 1'b1) begin fails++; $display("FAIL rmid_host_next: got %b want 1", host_gnt); end
    step();
    idle_inputs();
    @(negedge CPUclk);
    tests++; if ({host_rvalid, rdata} !== {1'b1, 16'hA031}) begin fails++; $display("FAIL rmid_host_rd: rvalid/rdata got %b/%h want 1/a031", host_rvalid, rdata); end
    step();
  endtask

  task automatic test_cpu_write();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int k = 0; k < 4; k++) begin
      a = 15'h0040 + 15'(k);
      d = 16'($urandom);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d; host_req = 1'b0;
      @(negedge CPUclk);
      tests++; if ({cpu_gnt, ram_we} !== 2'b11) begin fails++; $display("FAIL cw_%0d_we: gnt/we got %b want 11", k, {cpu_gnt, ram_we}); end
      tests++; if (ram_addr !== a) begin fails++; $display("FAIL cw_%0d_addr: got %h want %h", k, ram_addr, a); end
      tests++; if (ram_wdata !== d) begin fails++; $display("FAIL cw_%0d_wdata: got %h want %h", k, ram_wdata, d); end
      tests++; if ({cpu_rvalid, host_rvalid} !== 2'b00) begin fails++; $display("FAIL cw_%0d_rvalid: got %b want 00", k, {cpu_rvalid, host_rvalid}); end
      $display("tx: CPU wr addr=%h data=%h", a, d);
      step();
    end
    idle_inputs();
    @(negedge CPUclk);
    tests++; if ({cpu_rvalid, host_rvalid} !== 2'b00) begin fails++; $display("FAIL cw_tail_rvalid: got %b want 00", {cpu_rvalid, host_rvalid}); end
    step();
  endtask

  // Randomized traffic checked against a behavioural model: a shadow copy of
  // memory, a count of CPU wins while the host waits, and the host lock.
  task automatic test_random();
    logic [DW-1:0] shadow [0:255];
    int            streak;
    bit            mlock, cpu_pend, host_pend, ec, eh, exp_crv, exp_hrv, exp_we;
    logic [DW-1:0] exp_rd;
    for (int i = 0; i < 256; i++) shadow[i] = ram_mem[i];
    streak = 0; mlock = 0; cpu_pend = 0; host_pend = 0;
    exp_crv = 0; exp_hrv = 0; exp_rd = '0;
    host_lock = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (!cpu_pend && ($urandom_range(0, 2) != 0)) begin
        cpu_pend = 1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 15'($urandom_range(0, 15)); cpu_wdata = 16'($urandom);
      end
      if (!host_pend && ($urandom_range(0, 1) != 0)) begin
        host_pend = 1; host_we = 1'($urandom_range(0, 1));
        host_addr = 15'($urandom_range(0, 15)); host_wdata = 16'($urandom);
      end
      cpu_req  = cpu_pend;
      host_req = host_pend;
      if ($urandom_range(0, 5) == 0) host_lock = ~host_lock;
      @(negedge CPUclk);
      ec = 0; eh = 0;
      if (mlock && host_lock) eh = host_req;
      else if (host_req && (!cpu_req || streak >= MAXC)) eh = 1;
      else if (cpu_req) ec = 1;
      exp_we = (ec && cpu_we) || (eh && host_we);
      tests++; if ({cpu_gnt, host_gnt} !== {ec, eh}) begin fails++; $display("FAIL rnd_%0d_gnt: got %b want %b", cyc, {cpu_gnt, host_gnt}, {ec, eh}); end
      tests++; if (cpu_stall !== (cpu_req && !ec)) begin fails++; $display("FAIL rnd_%0d_stall: got %b want %b", cyc, cpu_stall, cpu_req && !ec); end
      tests++; if (ram_we !== exp_we) begin fails++; $display("FAIL rnd_%0d_ram_we: got %b want %b", cyc, ram_we, exp_we); end
      tests++; if (ram_addr !== (eh ? host_addr : cpu_addr)) begin fails++; $display("FAIL rnd_%0d_ram_addr: got %h want %h", cyc, ram_addr, eh ? host_addr : cpu_addr); end
      if (exp_we) begin
        tests++; if (ram_wdata !== (eh ? host_wdata : cpu_wdata)) begin fails++; $display("FAIL rnd_%0d_ram_wdata: got %h want %h", cyc, ram_wdata, eh ? host_wdata : cpu_wdata); end
      end
      tests++; if ({cpu_rvalid, host_rvalid} !== {exp_crv, exp_hrv}) begin fails++; $display("FAIL rnd_%0d_rvalid: got %b want %b", cyc, {cpu_rvalid, host_rvalid}, {exp_crv, exp_hrv}); end
      if (exp_crv || exp_hrv) begin
        tests++; if (rdata !== exp_rd) begin fails++; $display("FAIL rnd_%0d_rdata: got %h want %h", cyc, rdata, exp_rd); end
      end
      exp_crv = ec && !cpu_we;
      exp_hrv = eh && !host_we;
      if (ec) begin
        if (cpu_we) shadow[cpu_addr[7:0]] = cpu_wdata; else exp_rd = shadow[cpu_addr[7:0]];
        cpu_pend = 0;
        $display("tx: rnd cyc=%0d CPU %s addr=%h data=%h", cyc, cpu_we ? "wr" : "rd", cpu_addr, cpu_we ? cpu_wdata : exp_rd);
      end
      if (eh) begin
        if (host_we) shadow[host_addr[7:0]] = host_wdata; else exp_rd = shadow[host_addr[7:0]];
        host_pend = 0;
        $display("tx: rnd cyc=%0d HOST %s addr=%h data=%h lock=%b", cyc, host_we ? "wr" : "rd", host_addr, host_we ? host_wdata : exp_rd, host_lock);
      end
      if (eh || !host_req) streak = 0;
      else if (ec) streak = (streak < MAXC) ? streak + 1 : MAXC;
      if (!host_lock) mlock = 0;
      else if (eh) mlock = 1;
      step();
    end
    idle_inputs();
    host_lock = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    host_lock = 1'b0;
    rst       = 1'b1;
    ram_init  = 1'b1;
    step();
    ram_init  = 1'b0;
    test_reset();
    test_cpu_only();
    test_starvation();
    test_host_write_cpu_read();
    test_lock();
    test_reset_mid();
    test_cpu_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
